// File: rtl/vr_rr_packet_arbiter.sv
// rtl/vr_rr_packet_arbiter.sv - N-source round-robin packet arbiter with registered output
//
// Merges NUM_SRC valid/ready producers into one valid/ready stream. A source
// that wins keeps the output until its last beat is accepted.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   in_valid/in_data/in_last/in_ready   per-source input streams
//   out_valid/out_data/out_last/out_src registered merged output stream
//   out_ready            downstream accepts the output beat
module vr_rr_packet_arbiter #(
  parameter type DATA_T = logic [7:0],
  parameter int  NUM_SRC = 4,
  localparam int SRC_W = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] in_valid,
  input  DATA_T              in_data [NUM_SRC],
  input  logic [NUM_SRC-1:0] in_last,
  output logic [NUM_SRC-1:0] in_ready,
  output logic               out_valid,
  output DATA_T              out_data,
  output logic               out_last,
  output logic [SRC_W-1:0]   out_src,
  input  logic               out_ready
);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0] lock_src_q, lock_src_d;

  logic             load_en;
  logic             grant_vld;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W-1:0] cand;
  logic             xfer;
  logic             xfer_last;

  // The output register can take a new beat when empty or draining now.
  assign load_en = !out_valid || out_ready;

  // Grant selection: rotating priority starting at rr_ptr in ARB; in LOCKED
  // the owner keeps the grant even while idle, so bubbles never let another
  // source interleave into the packet.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (state_q == LOCKED) begin
      grant_vld = 1'b1;
      grant_idx = lock_src_q;
    end else begin
      for (int k = 0; k < NUM_SRC; k++) begin
        cand = SRC_W'((int'(rr_ptr_q) + k) % NUM_SRC);
        if (!grant_vld && in_valid[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (load_en && grant_vld && !reset) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  assign xfer      = |(in_ready & in_valid);
  assign xfer_last = in_last[grant_idx];

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_src_d = lock_src_q;
    if (xfer) begin
      if (xfer_last) begin
        // Pointer moves only at packet end, to the source after the winner.
        state_d  = ARB;
        rr_ptr_d = SRC_W'((int'(grant_idx) + 1) % NUM_SRC);
      end else begin
        state_d    = LOCKED;
        lock_src_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      lock_src_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_src_q <= lock_src_d;
    end
  end

  // Output stage: load on transfer (also when draining, so no bubble),
  // empty when drained without a replacement, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant_idx];
      out_last  <= xfer_last;
      out_src   <= grant_idx;
    end else if (load_en) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vr_rr_packet_arbiter.sv
// tb/tb_vr_rr_packet_arbiter.sv - directed self-checking bench for vr_rr_packet_arbiter
module tb_vr_rr_packet_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] in_valid;
  logic [7:0] in_data [4];
  logic [3:0] in_last;
  logic [3:0] in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic [1:0] out_src;
  logic       out_ready;

  int checks;
  int errors;

  vr_rr_packet_arbiter #(.NUM_SRC(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 4'hF;
    in_last  = 4'hF;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (in_ready !== 4'b0000) begin
        errors++; $display("FAIL reset_in_ready got %b exp %b", in_ready, 4'b0000);
      end
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid);
      end
      checks++;
      if (out_src !== 2'd0) begin
        errors++; $display("FAIL reset_out_src got %0d exp 0", out_src);
      end
    end
    reset    = 1'b0;
    in_valid = 4'h0;
  endtask

  task automatic test_single_beat_rr();
    logic [3:0] exp_rdy;
    in_valid  = 4'hF;
    in_last   = 4'hF;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) in_data[i] = 8'h10 + 8'(i);
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_rdy = 4'b0001 << (k % 4);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL rr_in_ready beat %0d got %b exp %b", k, in_ready, exp_rdy);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'(k % 4) || out_data !== 8'h10 + 8'(k % 4)) begin
        errors++;
        $display("FAIL rr_out beat %0d got v=%b src=%0d data=%h exp v=1 src=%0d data=%h",
                 k, out_valid, out_src, out_data, k % 4, 8'h10 + 8'(k % 4));
      end
    end
    in_valid = 4'h0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL rr_drain_empty got %b exp 0", out_valid);
    end
  endtask

  // rr_ptr is 0 on entry; one src0 beat moves it to 1 before the packet.
  task automatic test_packet_lock();
    in_valid = 4'b0001; in_last = 4'hF; in_data[0] = 8'h00;
    tick();
    in_valid = 4'b0111; in_last = 4'b0101;
    in_data[1] = 8'hA1; in_data[2] = 8'h22; in_data[0] = 8'h05;
    for (int b = 0; b < 3; b++) begin
      in_data[1] = 8'hA1 + 8'(b);
      in_last[1] = (b == 2);
      #1;
      checks++;
      if (in_ready !== 4'b0010) begin
        errors++; $display("FAIL lock_in_ready beat %0d got %b exp 0010", b, in_ready);
      end
      tick();
      checks++;
      if (out_src !== 2'd1 || out_data !== 8'hA1 + 8'(b) || out_last !== (b == 2)) begin
        errors++;
        $display("FAIL lock_out beat %0d got src=%0d data=%h last=%b exp src=1 data=%h last=%b",
                 b, out_src, out_data, out_last, 8'hA1 + 8'(b), (b == 2));
      end
    end
    in_valid = 4'b0101;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      errors++; $display("FAIL lock_next_src2 got %b exp 0100", in_ready);
    end
    tick();
    checks++;
    if (out_src !== 2'd2 || out_data !== 8'h22) begin
      errors++; $display("FAIL lock_out_src2 got src=%0d data=%h exp src=2 data=22", out_src, out_data);
    end
    in_valid = 4'b0001;
    tick();
    checks++;
    if (out_src !== 2'd0 || out_data !== 8'h05) begin
      errors++; $display("FAIL lock_out_src0 got src=%0d data=%h exp src=0 data=05", out_src, out_data);
    end
    in_valid = 4'b0000;
    tick();
  endtask

  // rr_ptr is 1 on entry; src2 sends a 4-beat packet with a 5-cycle stall.
  task automatic test_backpressure();
    logic [7:0] d [4];
    logic [7:0] rcv [$];
    int         sidx;
    logic       acc;
    d[0] = 8'hC0; d[1] = 8'hC1; d[2] = 8'hC2; d[3] = 8'hC3;
    sidx = 0;
    in_last = 4'b0000;
    for (int c = 0; c < 14; c++) begin
      out_ready = !(c >= 2 && c <= 6);
      if (sidx < 4) begin
        in_valid   = 4'b0100;
        in_data[2] = d[sidx];
        in_last[2] = (sidx == 3);
      end else begin
        in_valid = 4'b0000;
      end
      #1;
      if (c >= 2 && c <= 6) begin
        checks++;
        if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 8'hC1) begin
          errors++;
          $display("FAIL bp_stall cyc %0d got rdy=%b v=%b data=%h exp rdy=0000 v=1 data=c1",
                   c, in_ready, out_valid, out_data);
        end
      end
      acc = in_valid[2] & in_ready[2];
      if (out_valid && out_ready) rcv.push_back(out_data);
      tick();
      if (acc) sidx++;
    end
    out_ready = 1'b1;
    checks++;
    if (rcv.size() != 4) begin
      errors++; $display("FAIL bp_count got %0d exp 4", rcv.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rcv[i] !== d[i]) begin
          errors++; $display("FAIL bp_data idx %0d got %h exp %h", i, rcv[i], d[i]);
        end
      end
    end
  endtask

  // rr_ptr is 3 on entry.
  task automatic test_locked_bubble();
    in_valid = 4'b1001; in_last = 4'b0001;
    in_data[3] = 8'hB0; in_data[0] = 8'h50;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin
      errors++; $display("FAIL bubble_first got %b exp 1000", in_ready);
    end
    tick();
    in_valid = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 4'b1000) begin
        errors++; $display("FAIL bubble_hold cyc %0d got %b exp 1000", c, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL bubble_out_valid cyc %0d got %b exp 0", c, out_valid);
      end
    end
    in_valid = 4'b1001; in_last[3] = 1'b1; in_data[3] = 8'hB1;
    tick();
    checks++;
    if (out_src !== 2'd3 || out_last !== 1'b1 || out_data !== 8'hB1) begin
      errors++;
      $display("FAIL bubble_last got src=%0d last=%b data=%h exp src=3 last=1 data=b1",
               out_src, out_last, out_data);
    end
    in_valid = 4'b0001;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++; $display("FAIL bubble_release got %b exp 0001", in_ready);
    end
    tick();
    in_valid = 4'b0000;
    tick();
  endtask

  // rr_ptr is 1 on entry.
  task automatic test_wrap_reset();
    in_valid = 4'b0100; in_last = 4'hF;
    tick();
    in_valid = 4'b1011;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin
      errors++; $display("FAIL wrap_src3 got %b exp 1000", in_ready);
    end
    tick();
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++; $display("FAIL wrap_to_0 got %b exp 0001", in_ready);
    end
    tick();
    in_valid = 4'b0010; in_last = 4'b0000;
    tick();
    checks++;
    if (out_src !== 2'd1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL wrap_lock_src1 got src=%0d v=%b exp src=1 v=1", out_src, out_valid);
    end
    reset = 1'b1; in_valid = 4'hF;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++; $display("FAIL midrst_in_ready got %b exp 0000", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_src !== 2'd0) begin
      errors++; $display("FAIL midrst_out got v=%b src=%0d exp v=0 src=0", out_valid, out_src);
    end
    reset = 1'b0; in_last = 4'hF;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++; $display("FAIL midrst_arb got %b exp 0001", in_ready);
    end
    tick();
    checks++;
    if (out_src !== 2'd0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_first got src=%0d v=%b exp src=0 v=1", out_src, out_valid);
    end
    in_valid = 4'b0000;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    in_valid  = 4'h0;
    in_last   = 4'h0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) in_data[i] = 8'h00;
    test_reset();
    test_single_beat_rr();
    test_packet_lock();
    test_backpressure();
    test_locked_bubble();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
